maxpool_relu_stage: RTL and testbench
=====================================

// Module: maxpool_relu_stage
// PURPOSE
//  Consumes the packed result stream of convolutional_layer (UNROLL int8 lanes per word, raster order,
//  one conv output row of dim pixels per row) and emits a 2x2, stride-2 signed max-pooled stream
//  in the same packed format. Sits directly downstream of convolutional_layer, feeding the next conv stage.
//  No backpressure: accepts one word per in_valid cycle, as convolutional_layer produces.
// PARAMETERS
//  UNROLL      4    number of packed lanes per word (lane k = bits [8k+7:8k])
//  DATA_WIDTH  8    bits per lane, two's complement
//  MAX_DIM     256  largest supported feature-map width/height; line buffer depth = MAX_DIM/2
// PORTS
//  clock      in   1                  rising-edge clock
//  reset      in   1                  asynchronous, active-low
//  dim        in   8                  input feature-map width = height (square), sampled at frame start
//  in_data    in   UNROLL*DATA_WIDTH  packed conv result word
//  in_valid   in   1                  in_data valid this cycle
//  out_data   out  UNROLL*DATA_WIDTH  packed pooled word
//  out_valid  out  1                  out_data valid this cycle
//  frame_done out  1                  1-cycle pulse after last input word of a frame
// BEHAVIOUR
//  - Reset: out_data=0, out_valid=0, frame_done=0, col=row=0, hreg=0, dim_q=0; line buffer not cleared.
//  - dim_q latched from dim on the first in_valid of a frame (col==0 && row==0); dim changes mid-frame ignored.
//  - Counters: col increments per accepted word; at col==dim_q-1 col wraps to 0 and row increments;
//    at row==dim_q-1 && col==dim_q-1 both wrap to 0 and frame_done pulses next cycle.
//  - Horizontal stage: even col -> hreg <= in_data; odd col -> hmax = lane-wise signed max(hreg, in_data).
//  - Even row, odd col: linebuf[col>>1] <= hmax. Odd row, odd col: out_data <= max(linebuf[col>>1], hmax),
//    out_valid=1 on the following cycle (latency 1 clock from the completing input word).
//  - out_valid is a 1-cycle pulse per pooled pixel; output count per frame = floor(dim/2)^2.
//  - Odd dim: last column (col==dim_q-1, even) and last row (row==dim_q-1, even) feed no output; still counted.
//  - dim_q < 2: words accepted and counted, no out_valid ever; frame_done pulses after dim_q*dim_q words
//    (dim_q==0 -> treated as 1, frame_done after every word).
//  - in_valid low: all state holds; gaps of any length allowed between words, including mid-row.
//  - Reset mid-frame: counters return to 0, next word starts a new frame; stale linebuf never read
//    before rewritten (even row always precedes odd row).
//  - Lanes independent; max compares as signed DATA_WIDTH; no widening, no saturation needed.
// CONFIGURATION
//  RELU_STAGE_EN defined: each lane clamped to max(x,0) on input before pooling (negatives -> 0);
//    outputs therefore never negative. Not defined: pure signed max-pool, negatives pass through.
// STRUCTURE
//  cnn_pkg: lane_t (logic signed [DATA_WIDTH-1:0]), packed word typedef, function lane_max(a,b)
//    (lane-wise signed max over UNROLL lanes), DIM_W = 8 constant.
//  Sub-module pool_line_buffer: single-port-write/async-read array, depth MAX_DIM/2, width
//    UNROLL*DATA_WIDTH, write enable + write addr + read addr; registered write, combinational read.
// TESTING
//  1. dim=4, words 0x01..0x10 in lane0 (others 0), RELU_STAGE_EN off -> 4 outputs lane0 = 0x06,0x08,0x0E,0x10;
//     frame_done 1 cycle after word 16.
//  2. dim=4, all lanes = 0xF0 except one word per 2x2 window = 0xFE -> every output lane = 0xFE (signed max);
//     with RELU_STAGE_EN -> all outputs 0x00.
//  3. dim=5, ramp input -> exactly 4 outputs, column 4 and row 4 ignored; frame_done after 25th word.
//  4. dim=222 continuous in_valid, two back-to-back frames -> 111*111 outputs per frame, out_valid 1 cycle
//     after each odd-row odd-col word, two frame_done pulses, no gap needed between frames.
//  5. dim=4 with random in_valid gaps (50%) -> outputs identical in value/order to scenario 1.
//  6. Assert reset after 9 words of dim=4 frame, release, send full frame -> exactly 4 correct outputs,
//     no output from the aborted frame; all outputs 0 during reset.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath stages.
// Packed words carry UNROLL signed lanes; lane k occupies bits [8k+7:8k].
package cnn_pkg;

  localparam int UNROLL     = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_DIM    = 256;
  localparam int DIM_W      = 8;
  localparam int WORD_W     = UNROLL * DATA_WIDTH;
  localparam int LB_DEPTH   = MAX_DIM / 2;
  localparam int LB_AW      = $clog2(LB_DEPTH);

  typedef logic signed [DATA_WIDTH-1:0] lane_t;
  typedef logic [WORD_W-1:0]            word_t;

  // Lane-wise signed maximum of two packed words.
  function automatic word_t lane_max(input word_t a, input word_t b);
    word_t r;
    lane_t la;
    lane_t lb;
    r = '0;
    for (int k = 0; k < UNROLL; k++) begin
      la = lane_t'(a[k*DATA_WIDTH +: DATA_WIDTH]);
      lb = lane_t'(b[k*DATA_WIDTH +: DATA_WIDTH]);
      r[k*DATA_WIDTH +: DATA_WIDTH] = (la > lb) ? la : lb;
    end
    return r;
  endfunction

  // Lane-wise clamp of negative values to zero.
  function automatic word_t lane_relu(input word_t a);
    word_t r;
    lane_t la;
    r = '0;
    for (int k = 0; k < UNROLL; k++) begin
      la = lane_t'(a[k*DATA_WIDTH +: DATA_WIDTH]);
      r[k*DATA_WIDTH +: DATA_WIDTH] = la[DATA_WIDTH-1] ? '0 : la;
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer holding one row of horizontally pooled words.
// Registered write, combinational read; contents are never cleared because
// every entry is rewritten on an even row before an odd row reads it.
module pool_line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the horizontal max of an even row at its pooled column.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_relu_stage.sv
// 2x2 stride-2 signed max-pool over the packed raster stream of the conv layer.
// Optional feature macro: RELU_STAGE_EN -- when defined every lane is clamped
// to max(x,0) on input, before pooling.
module maxpool_relu_stage
  import cnn_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DIM_W-1:0]             dim,
  input  logic [UNROLL*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic [UNROLL*DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic                         frame_done
);

  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] dim_q;
  logic [DIM_W-1:0] cur_dim;
  logic [DIM_W-1:0] last_idx;
  logic             frame_start;
  logic             last_col;
  logic             last_row;
  logic             lb_wr_en;
  logic             emit;
  logic [LB_AW-1:0] lb_addr;
  word_t            px;
  word_t            hreg;
  word_t            hmax;
  word_t            vmax;
  word_t            lb_rd;

`ifdef RELU_STAGE_EN
  assign px = lane_relu(in_data);
`else
  assign px = in_data;
`endif

  // On the first word of a frame the live dim input decides wrapping, since
  // dim_q only captures it at that same edge; dim 0 behaves as dim 1.
  assign frame_start = (col == '0) && (row == '0);
  assign cur_dim     = frame_start ? dim : dim_q;
  assign last_idx    = (cur_dim == '0) ? '0 : cur_dim - DIM_W'(1);
  assign last_col    = (col == last_idx);
  assign last_row    = (row == last_idx);

  assign hmax     = lane_max(hreg, px);
  assign vmax     = lane_max(lb_rd, hmax);
  assign lb_addr  = col[DIM_W-1:1];
  assign lb_wr_en = in_valid && col[0] && !row[0];
  assign emit     = in_valid && col[0] && row[0];

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .WIDTH (WORD_W),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  // Raster position counters, frame-size latch and end-of-frame pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      dim_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_valid) begin
        if (frame_start) begin
          dim_q <= dim;
        end
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + DIM_W'(1);
          end
        end else begin
          col <= col + DIM_W'(1);
        end
      end
    end
  end

  // Hold the left pixel of each horizontal pair until its partner arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hreg <= '0;
    end else if (in_valid && !col[0]) begin
      hreg <= px;
    end
  end

  // Emit the pooled word one clock after the bottom-right pixel of a window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_data <= vmax;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_relu_stage.sv
// Self-checking bench for maxpool_relu_stage.
// Expected pooled words are queued when the completing input word is driven
// and popped when out_valid is seen; out_valid/frame_done timing is checked
// every cycle against flags set by the driver.
module tb_maxpool_relu_stage;
  import cnn_pkg::*;

  localparam int P_RAMP0 = 0;
  localparam int P_RAND  = 1;
  localparam int P_PEAK  = 2;

  typedef struct {
    int dim;
    int pattern;
    int gap_pct;
    int b2b;
    int exp_outputs;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [DIM_W-1:0] dim;
  word_t            in_data;
  logic             in_valid;
  word_t            out_data;
  logic             out_valid;
  logic             frame_done;

  int    n_compared   = 0;
  int    n_mismatched = 0;
  int    out_count    = 0;
  logic  exp_ov       = 1'b0;
  logic  exp_fd       = 1'b0;
  word_t sb_q[$];
  word_t frame_mem [0:65535];
  vec_t  vecs [10];

  always #5 clock = ~clock;

  maxpool_relu_stage dut (
    .clock      (clock),
    .reset      (reset),
    .dim        (dim),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Per-cycle check of handshake timing and popped scoreboard values.
  always @(negedge clock) begin
    check_output("out_valid", 32'(out_valid), 32'(exp_ov));
    check_output("frame_done", 32'(frame_done), 32'(exp_fd));
    if (out_valid) begin
      out_count++;
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_out: got %h, expected no output", out_data);
      end else begin
        check_output("out_data", out_data, sb_q.pop_front());
      end
    end
  end

  function automatic word_t relu_w(input word_t w);
`ifdef RELU_STAGE_EN
    word_t r;
    r = w;
    for (int k = 0; k < UNROLL; k++) begin
      if (w[k*DATA_WIDTH + DATA_WIDTH - 1]) r[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
`else
    return w;
`endif
  endfunction

  function automatic word_t max_w(input word_t a, input word_t b);
    word_t r;
    int x;
    int y;
    r = '0;
    for (int k = 0; k < UNROLL; k++) begin
      x = int'($signed(a[k*DATA_WIDTH +: DATA_WIDTH]));
      y = int'($signed(b[k*DATA_WIDTH +: DATA_WIDTH]));
      r[k*DATA_WIDTH +: DATA_WIDTH] = (x < y) ? b[k*DATA_WIDTH +: DATA_WIDTH] : a[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  function automatic word_t window_max(input int d, input int r, input int c);
    word_t m;
    m = relu_w(frame_mem[(r-1)*d + c-1]);
    m = max_w(m, relu_w(frame_mem[(r-1)*d + c]));
    m = max_w(m, relu_w(frame_mem[r*d + c-1]));
    m = max_w(m, relu_w(frame_mem[r*d + c]));
    return m;
  endfunction

  task automatic fill_frame(input int dim_cfg, input int pattern);
    int d;
    int k;
    d = (dim_cfg == 0) ? 1 : dim_cfg;
    for (int i = 0; i < d*d; i++) begin
      case (pattern)
        P_RAMP0: frame_mem[i] = word_t'((i + 1) & 255);
        P_PEAK:  frame_mem[i] = 32'hF0F0F0F0;
        default: frame_mem[i] = word_t'($urandom);
      endcase
    end
    if (pattern == P_PEAK) begin
      for (int wr = 0; wr < d/2; wr++) begin
        for (int wc = 0; wc < d/2; wc++) begin
          k = (wr*2 + wc) % 4;
          frame_mem[(2*wr + k/2)*d + 2*wc + k%2] = 32'hFEFEFEFE;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
      exp_ov = 1'b0;
      exp_fd = 1'b0;
    end
  endtask

  // Drive nwords of the frame in frame_mem; dim is only valid on the first
  // word and garbage afterwards to show it is ignored mid-frame.
  task automatic apply_stimulus(input int dim_cfg, input int nwords, input int gap_pct, input bit use_model);
    int  d;
    int  r;
    int  c;
    bit  emit;
    d = (dim_cfg == 0) ? 1 : dim_cfg;
    for (int idx = 0; idx < nwords; idx++) begin
      if (gap_pct > 0) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          in_valid = 1'b0;
          in_data  = word_t'($urandom);
          @(posedge clock);
          #1;
          exp_ov = 1'b0;
          exp_fd = 1'b0;
        end
      end
      r = idx / d;
      c = idx % d;
      dim      = (idx == 0) ? DIM_W'(dim_cfg) : DIM_W'($urandom);
      in_data  = frame_mem[idx];
      in_valid = 1'b1;
      emit     = (r % 2 == 1) && (c % 2 == 1);
      if (emit && use_model) sb_q.push_back(window_max(d, r, c));
      @(posedge clock);
      #1;
      exp_ov = emit;
      exp_fd = (idx == d*d - 1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int    base;
    int    pending;
    word_t exp_peak;

    vecs = '{
      '{6,   P_RAND, 0,  0, 9},
      '{7,   P_RAND, 30, 0, 9},
      '{2,   P_RAND, 50, 0, 1},
      '{3,   P_RAND, 0,  0, 1},
      '{1,   P_RAND, 0,  1, 0},
      '{0,   P_RAND, 0,  1, 0},
      '{1,   P_RAND, 20, 0, 0},
      '{222, P_RAND, 0,  1, 12321},
      '{8,   P_RAND, 0,  0, 16},
      '{9,   P_PEAK, 40, 0, 16}
    };

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    dim      = '0;
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_out_data", out_data, 32'h0);
    check_output("reset_out_valid", 32'(out_valid), 32'h0);
    check_output("reset_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b1;
    idle(2);

    // dim=4 lane0 ramp, continuous.
    base = out_count;
    fill_frame(4, P_RAMP0);
    sb_q.push_back(32'h06); sb_q.push_back(32'h08);
    sb_q.push_back(32'h0E); sb_q.push_back(32'h10);
    apply_stimulus(4, 16, 0, 1'b0);
    idle(2);
    check_output("ramp4_count", 32'(out_count - base), 32'd4);

    // Same frame with random gaps: same values and order.
    base = out_count;
    sb_q.push_back(32'h06); sb_q.push_back(32'h08);
    sb_q.push_back(32'h0E); sb_q.push_back(32'h10);
    apply_stimulus(4, 16, 50, 1'b0);
    idle(2);
    check_output("ramp4_gap_count", 32'(out_count - base), 32'd4);

    // Negative background with one peak per window.
`ifdef RELU_STAGE_EN
    exp_peak = 32'h00000000;
`else
    exp_peak = 32'hFEFEFEFE;
`endif
    base = out_count;
    fill_frame(4, P_PEAK);
    repeat (4) sb_q.push_back(exp_peak);
    apply_stimulus(4, 16, 0, 1'b0);
    idle(2);
    check_output("peak4_count", 32'(out_count - base), 32'd4);

    // Odd dim: column 4 and row 4 produce nothing.
    base = out_count;
    fill_frame(5, P_RAMP0);
    sb_q.push_back(32'h07); sb_q.push_back(32'h09);
    sb_q.push_back(32'h11); sb_q.push_back(32'h13);
    apply_stimulus(5, 25, 0, 1'b0);
    idle(2);
    check_output("ramp5_count", 32'(out_count - base), 32'd4);

    // Table of frames; b2b entries run straight into the next one.
    base    = out_count;
    pending = 0;
    for (int v = 0; v < 10; v++) begin
      fill_frame(vecs[v].dim, vecs[v].pattern);
      apply_stimulus(vecs[v].dim, (vecs[v].dim == 0) ? 1 : vecs[v].dim * vecs[v].dim, vecs[v].gap_pct, 1'b1);
      pending += vecs[v].exp_outputs;
      if (vecs[v].b2b == 0) begin
        idle(2);
        check_output($sformatf("table%0d_count", v), 32'(out_count - base), 32'(pending));
        base    = out_count;
        pending = 0;
      end
    end

    // Abort a frame after 9 words with reset, then send a clean frame.
    base = out_count;
    fill_frame(4, P_RAMP0);
    apply_stimulus(4, 9, 0, 1'b1);
    idle(1);
    reset = 1'b0;
    #1;
    check_output("abort_out_data", out_data, 32'h0);
    repeat (3) begin
      @(posedge clock);
      #1;
      check_output("abort_out_data", out_data, 32'h0);
      check_output("abort_out_valid", 32'(out_valid), 32'h0);
    end
    reset = 1'b1;
    check_output("abort_count", 32'(out_count - base), 32'd2);
    base = out_count;
    sb_q.push_back(32'h06); sb_q.push_back(32'h08);
    sb_q.push_back(32'h0E); sb_q.push_back(32'h10);
    apply_stimulus(4, 16, 0, 1'b0);
    idle(3);
    check_output("after_abort_count", 32'(out_count - base), 32'd4);

    check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
